// File: rtl/fsm_codes_pkg.sv
// State codes shared by the upstream run detector and the run event monitor.
// Codes at or above CODE_ILLEGAL_MIN never come out of a healthy detector.
package fsm_codes_pkg;

  typedef enum logic [3:0] {
    CODE_A = 4'd0,
    CODE_B = 4'd1,
    CODE_C = 4'd2,
    CODE_D = 4'd3,
    CODE_E = 4'd4,
    CODE_F = 4'd5,
    CODE_G = 4'd6,
    CODE_H = 4'd7,
    CODE_I = 4'd8
  } state_code_e;

  localparam logic [3:0] CODE_ILLEGAL_MIN = 4'd9;

  function automatic logic is_illegal(input logic [3:0] code);
    return code >= CODE_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clr_i zeroes the base value, inc_i adds one on top of it,
// so clr_i and inc_i together load 1. cnt_d_o exposes the value the next edge will store.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_d_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] base_d;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    base_d = clr_i ? '0 : cnt_q;
    cnt_d  = (inc_i && (base_d != CNT_MAX)) ? (base_d + CNT_ONE) : base_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;

endmodule

// File: rtl/run_event_monitor.sv
// Watches the run-detector state code and reports run entries, dwell time, maxima and
// illegal codes. z is registered once, the FSM and all outputs once more: two cycles in to out.
module run_event_monitor
  import fsm_codes_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       z,
  input  logic             clr,
  output logic             zero_evt,
  output logic             one_evt,
  output logic [CNT_W-1:0] zero_cnt,
  output logic [CNT_W-1:0] one_cnt,
  output logic [CNT_W-1:0] dwell,
  output logic [CNT_W-1:0] max_zero,
  output logic [CNT_W-1:0] max_one,
  output logic             err_evt,
  output logic             err_sticky
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ZRUN = 2'd1,
    ST_ORUN = 2'd2,
    ST_ERR  = 2'd3
  } mon_state_e;

  logic [3:0]       z_q;
  mon_state_e       state_q, state_d;
  logic             zero_evt_q, one_evt_q, err_evt_q, err_sticky_q;
  logic [CNT_W-1:0] max_zero_q, max_one_q;
  logic             run_d, hold_d, zero_entry_d, one_entry_d, err_d;
  logic [CNT_W-1:0] dwell_d;
  logic [CNT_W-1:0] zero_cnt_nxt_unused, one_cnt_nxt_unused;

  // Next state depends only on the registered code, so every state shares the same rules.
  always_comb begin
    state_d = ST_IDLE;
    if (z_q == CODE_E) begin
      state_d = ST_ZRUN;
    end else if (z_q == CODE_I) begin
      state_d = ST_ORUN;
    end else if (is_illegal(z_q)) begin
      state_d = ST_ERR;
    end
  end

  assign run_d        = (state_d == ST_ZRUN) || (state_d == ST_ORUN);
  assign hold_d       = run_d && (state_d == state_q);
  assign zero_entry_d = (state_d == ST_ZRUN) && (state_q != ST_ZRUN);
  assign one_entry_d  = (state_d == ST_ORUN) && (state_q != ST_ORUN);
  assign err_d        = (state_d == ST_ERR);

  // clr must win over a coincident event, so the increment is masked rather than combined.
  sat_counter #(.CNT_W(CNT_W)) u_zero_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (clr),
    .inc_i   (zero_entry_d && !clr),
    .cnt_o   (zero_cnt),
    .cnt_d_o (zero_cnt_nxt_unused)
  );

  sat_counter #(.CNT_W(CNT_W)) u_one_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (clr),
    .inc_i   (one_entry_d && !clr),
    .cnt_o   (one_cnt),
    .cnt_d_o (one_cnt_nxt_unused)
  );

  // Entering a run clears and increments in the same cycle, which loads 1.
  sat_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (!hold_d),
    .inc_i   (run_d),
    .cnt_o   (dwell),
    .cnt_d_o (dwell_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      z_q          <= CODE_A;
      state_q      <= ST_IDLE;
      zero_evt_q   <= 1'b0;
      one_evt_q    <= 1'b0;
      err_evt_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      max_zero_q   <= '0;
      max_one_q    <= '0;
    end else begin
      z_q        <= z;
      state_q    <= state_d;
      zero_evt_q <= zero_entry_d;
      one_evt_q  <= one_entry_d;
      err_evt_q  <= err_d;
      if (clr) begin
        err_sticky_q <= 1'b0;
        max_zero_q   <= '0;
        max_one_q    <= '0;
      end else begin
        if (err_d) begin
          err_sticky_q <= 1'b1;
        end
        if ((state_d == ST_ZRUN) && (dwell_d > max_zero_q)) begin
          max_zero_q <= dwell_d;
        end
        if ((state_d == ST_ORUN) && (dwell_d > max_one_q)) begin
          max_one_q <= dwell_d;
        end
      end
    end
  end

  assign zero_evt   = zero_evt_q;
  assign one_evt    = one_evt_q;
  assign err_evt    = err_evt_q;
  assign err_sticky = err_sticky_q;
  assign max_zero   = max_zero_q;
  assign max_one    = max_one_q;

endmodule

// File: tb/tb_run_event_monitor.sv
// Self-checking bench for run_event_monitor: a behavioural model queues the expected
// output vector for every clock, and each scenario task compares it plus spot values.
module tb_run_event_monitor;

  localparam int CNT_W = 8;
  localparam int MAXV  = 255;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       z = 4'd0;
  logic             clr = 1'b0;
  logic             zero_evt, one_evt, err_evt, err_sticky;
  logic [CNT_W-1:0] zero_cnt, one_cnt, dwell, max_zero, max_one;

  always #5 clk = ~clk;

  run_event_monitor #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .z          (z),
    .clr        (clr),
    .zero_evt   (zero_evt),
    .one_evt    (one_evt),
    .zero_cnt   (zero_cnt),
    .one_cnt    (one_cnt),
    .dwell      (dwell),
    .max_zero   (max_zero),
    .max_one    (max_one),
    .err_evt    (err_evt),
    .err_sticky (err_sticky)
  );

  typedef logic [43:0] vec_t;
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: m_st 0=idle 1=zero run 2=one run 3=error
  int m_zq = 0, m_st = 0, m_zcnt = 0, m_ocnt = 0, m_dwell = 0, m_maxz = 0, m_maxo = 0;
  bit m_zevt = 0, m_oevt = 0, m_erre = 0, m_sticky = 0;

  function automatic vec_t dut_vec();
    return {zero_evt, one_evt, zero_cnt, one_cnt, dwell, max_zero, max_one, err_evt, err_sticky};
  endfunction

  task automatic step(input logic [3:0] zi, input logic ci, input logic ri);
    int nst;
    @(negedge clk);
    z = zi; clr = ci; reset = ri;
    @(posedge clk);
    #1;
    if (ri) begin
      m_zq = 0; m_st = 0; m_zcnt = 0; m_ocnt = 0; m_dwell = 0; m_maxz = 0; m_maxo = 0;
      m_zevt = 0; m_oevt = 0; m_erre = 0; m_sticky = 0;
    end else begin
      nst = (m_zq == 4) ? 1 : (m_zq == 8) ? 2 : (m_zq >= 9) ? 3 : 0;
      m_zevt = (nst == 1) && (m_st != 1);
      m_oevt = (nst == 2) && (m_st != 2);
      if (nst == 1 || nst == 2)
        m_dwell = (nst == m_st) ? ((m_dwell < MAXV) ? m_dwell + 1 : MAXV) : 1;
      else
        m_dwell = 0;
      m_erre = (nst == 3);
      if (ci) begin
        m_zcnt = 0; m_ocnt = 0; m_maxz = 0; m_maxo = 0; m_sticky = 0;
      end else begin
        if (m_zevt && m_zcnt < MAXV) m_zcnt++;
        if (m_oevt && m_ocnt < MAXV) m_ocnt++;
        if (nst == 1 && m_dwell > m_maxz) m_maxz = m_dwell;
        if (nst == 2 && m_dwell > m_maxo) m_maxo = m_dwell;
        if (m_erre) m_sticky = 1;
      end
      m_st = nst;
      m_zq = int'(zi);
    end
    exp_q.push_back({m_zevt, m_oevt, 8'(m_zcnt), 8'(m_ocnt), 8'(m_dwell), 8'(m_maxz),
                     8'(m_maxo), m_erre, m_sticky});
  endtask

  task automatic test_reset();
    vec_t ev;
    for (int i = 0; i < 3; i++) begin
      step(4'hC, 1'b1, 1'b1);
      ev = exp_q.pop_front();
      checks++;
      if (dut_vec() !== ev) begin
        errors++;
        $display("FAIL reset step %0d: got %h expected %h", i, dut_vec(), ev);
      end
      checks++;
      if (dut_vec() !== 44'h0) begin
        errors++;
        $display("FAIL reset_zero step %0d: got %h expected 0", i, dut_vec());
      end
    end
  endtask

  task automatic test_zero_run();
    logic [3:0] seq [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd0, 4'd0, 4'd0};
    int dexp [4] = '{1, 2, 3, 0};
    int dw [10];
    int pulses = 0, pulse_at = -1;
    vec_t ev;
    step(4'd0, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 10; i++) begin
      step(seq[i], 1'b0, 1'b0);
      ev = exp_q.pop_front();
      checks++;
      if (dut_vec() !== ev) begin
        errors++;
        $display("FAIL zero_run step %0d: got %h expected %h", i, dut_vec(), ev);
      end
      dw[i] = int'(dwell);
      if (zero_evt) begin pulses++; pulse_at = i; end
    end
    checks++;
    if (pulses !== 1 || pulse_at !== 5) begin
      errors++;
      $display("FAIL zero_run_pulse: got %0d pulses at step %0d, expected 1 at step 5", pulses, pulse_at);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dw[5+k] !== dexp[k]) begin
        errors++;
        $display("FAIL zero_run_dwell %0d: got %0d expected %0d", k, dw[5+k], dexp[k]);
      end
    end
    checks++;
    if (max_zero !== 8'd3 || zero_cnt !== 8'd1) begin
      errors++;
      $display("FAIL zero_run_final: max_zero %0d zero_cnt %0d, expected 3 and 1", max_zero, zero_cnt);
    end
  endtask

  task automatic test_one_saturate();
    int pulses = 0, peak = 0;
    vec_t ev;
    step(4'd0, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 303; i++) begin
      step((i < 300) ? 4'd8 : 4'd0, 1'b0, 1'b0);
      ev = exp_q.pop_front();
      checks++;
      if (dut_vec() !== ev) begin
        errors++;
        $display("FAIL one_sat step %0d: got %h expected %h", i, dut_vec(), ev);
      end
      if (one_evt) pulses++;
      if (int'(dwell) > peak) peak = int'(dwell);
    end
    checks++;
    if (pulses !== 1 || peak !== 255 || max_one !== 8'd255 || one_cnt !== 8'd1) begin
      errors++;
      $display("FAIL one_sat_final: pulses %0d peak %0d max_one %0d one_cnt %0d, expected 1 255 255 1",
               pulses, peak, max_one, one_cnt);
    end
  endtask

  task automatic test_cnt_saturate();
    int pulses = 0;
    vec_t ev;
    step(4'd0, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 522; i++) begin
      step((i < 520 && (i % 2) == 0) ? 4'd4 : 4'd0, 1'b0, 1'b0);
      ev = exp_q.pop_front();
      checks++;
      if (dut_vec() !== ev) begin
        errors++;
        $display("FAIL cnt_sat step %0d: got %h expected %h", i, dut_vec(), ev);
      end
      if (zero_evt) pulses++;
    end
    checks++;
    if (pulses !== 260 || zero_cnt !== 8'd255) begin
      errors++;
      $display("FAIL cnt_sat_final: pulses %0d zero_cnt %0d, expected 260 and 255", pulses, zero_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [5] = '{4'd4, 4'd8, 4'd0, 4'd0, 4'd0};
    logic [1:0] evts [5];
    int dw [5];
    vec_t ev;
    step(4'd0, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      step(seq[i], 1'b0, 1'b0);
      ev = exp_q.pop_front();
      checks++;
      if (dut_vec() !== ev) begin
        errors++;
        $display("FAIL b2b step %0d: got %h expected %h", i, dut_vec(), ev);
      end
      evts[i] = {zero_evt, one_evt};
      dw[i] = int'(dwell);
    end
    checks++;
    if (evts[1] !== 2'b10 || evts[2] !== 2'b01 || dw[1] !== 1 || dw[2] !== 1) begin
      errors++;
      $display("FAIL b2b_seq: evts %b %b dwell %0d %0d, expected 10 01 dwell 1 1",
               evts[1], evts[2], dw[1], dw[2]);
    end
    checks++;
    if (zero_cnt !== 8'd1 || one_cnt !== 8'd1) begin
      errors++;
      $display("FAIL b2b_counts: zero_cnt %0d one_cnt %0d, expected 1 1", zero_cnt, one_cnt);
    end
  endtask

  task automatic test_error();
    logic [3:0] seq [5] = '{4'd12, 4'd12, 4'd0, 4'd0, 4'd0};
    int errs = 0;
    vec_t ev;
    step(4'd0, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 6; i++) begin
      step((i < 5) ? seq[i] : 4'd0, (i == 5), 1'b0);
      ev = exp_q.pop_front();
      checks++;
      if (dut_vec() !== ev) begin
        errors++;
        $display("FAIL err step %0d: got %h expected %h", i, dut_vec(), ev);
      end
      if (err_evt) errs++;
      if (i == 4) begin
        checks++;
        if (errs !== 2 || err_sticky !== 1'b1) begin
          errors++;
          $display("FAIL err_sticky_hold: err_evt cycles %0d sticky %b, expected 2 and 1", errs, err_sticky);
        end
      end
    end
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: err_sticky %b expected 0", err_sticky);
    end
  endtask

  task automatic test_clr_and_reset();
    vec_t ev;
    step(4'd0, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 8; i++) begin
      step((i < 2) ? 4'd4 : 4'd8, (i == 1), 1'b0);
      ev = exp_q.pop_front();
      checks++;
      if (dut_vec() !== ev) begin
        errors++;
        $display("FAIL clr_evt step %0d: got %h expected %h", i, dut_vec(), ev);
      end
      if (i == 1) begin
        checks++;
        if (zero_evt !== 1'b1 || zero_cnt !== 8'd0) begin
          errors++;
          $display("FAIL clr_vs_evt: zero_evt %b zero_cnt %0d, expected 1 and 0", zero_evt, zero_cnt);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(4'd0, 1'b0, (i == 0));
      ev = exp_q.pop_front();
      checks++;
      if (dut_vec() !== 44'h0 || dut_vec() !== ev) begin
        errors++;
        $display("FAIL reset_mid_run step %0d: got %h expected 0", i, dut_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] zr;
    int r;
    vec_t ev;
    step(4'd0, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3)       zr = 4'd4;
      else if (r < 6)  zr = 4'd8;
      else if (r == 6) zr = 4'($urandom_range(9, 15));
      else             zr = 4'($urandom_range(0, 8));
      step(zr, ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0));
      ev = exp_q.pop_front();
      checks++;
      if (dut_vec() !== ev) begin
        errors++;
        $display("FAIL random step %0d: got %h expected %h", i, dut_vec(), ev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_run();
    test_one_saturate();
    test_cnt_saturate();
    test_back_to_back();
    test_error();
    test_clr_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_event_monitor.md
RUN_EVENT_MONITOR -- requirements
Module: run_event_monitor

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of all counters and dwell/maximum registers; legal range 2..16.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on the rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 z  input  4  SHALL carry the state code of the upstream run-detector FSM: A=0 through I=8; codes 9..15 are illegal.
REQ-005 clr  input  1  SHALL be a synchronous clear of the counters, the maximum registers and the sticky error.
REQ-006 zero_evt  output  1  SHALL be a one-cycle pulse marking entry into a run of four or more zeros.
REQ-007 one_evt  output  1  SHALL be a one-cycle pulse marking entry into a run of four or more ones.
REQ-008 zero_cnt, one_cnt  output  CNT_W  SHALL hold the saturating counts of zero_evt and one_evt pulses.
REQ-009 dwell  output  CNT_W  SHALL hold the saturating count of consecutive cycles spent in the current E or I run.
REQ-010 max_zero, max_one  output  CNT_W  SHALL hold the largest dwell value reached in E and in I, respectively.
REQ-011 err_evt  output  1  SHALL pulse for one cycle on each sampled illegal code.
REQ-012 err_sticky  output  1  SHALL latch high after any illegal code and hold until clr or reset.

Function
REQ-013 z SHALL be registered once before use; every output SHALL be registered. Input-to-output latency: an event present on z in cycle N appears on the outputs in cycle N+2.
REQ-014 The monitor FSM SHALL have the states IDLE, ZRUN, ORUN and ERR.
REQ-015 FSM transitions, on the registered code z_q:
- z_q=E: next state ZRUN.
- z_q=I: next state ORUN.
- z_q in 9..15: next state ERR.
- any other code: next state IDLE.
- These rules apply from every state; ERR recovers on the next legal code.
REQ-016 zero_evt SHALL assert when the FSM enters ZRUN from any state other than ZRUN; one_evt SHALL assert likewise on entry to ORUN.
REQ-017 A direct ZRUN->ORUN or ORUN->ZRUN transition SHALL count as a new event.
REQ-018 dwell behaviour:
- SHALL be 1 on the cycle a run is entered.
- SHALL increment each further cycle the run is held.
- SHALL saturate at 2^CNT_W-1.
- SHALL become 0 in IDLE and in ERR.
REQ-019 On every cycle in ZRUN (respectively ORUN), max_zero (max_one) SHALL update to dwell when dwell exceeds it.
REQ-020 zero_cnt and one_cnt SHALL increment by 1 per event and saturate at 2^CNT_W-1 without wrapping.
REQ-021 err_evt SHALL assert on every cycle in ERR, not only on entry.
REQ-022 clr SHALL zero zero_cnt, one_cnt, max_zero, max_one and err_sticky.
REQ-023 clr SHALL NOT affect the FSM state, dwell, zero_evt, one_evt or err_evt.
REQ-024 When clr coincides with an event, clr wins: the counter becomes 0, and the pulse is still emitted.
REQ-025 When clr coincides with an illegal code, err_sticky becomes 0 that cycle and sets on the next illegal cycle.

Reset
REQ-026 While reset is high, the following SHALL be forced on the next edge:
- z_q to A.
- The FSM to IDLE.
- Every output to 0.
REQ-027 reset SHALL take priority over clr and over all input activity.
REQ-028 A reset asserted mid-run SHALL abort the run without emitting an event or a maximum update.

Structure
REQ-029 The state codes A..I and the illegal-code threshold (9) SHALL live in the shared package fsm_codes_pkg, used by both the run-detector and this block.
REQ-030 The monitor FSM state encoding SHALL be local to this module.
REQ-031 One sub-module, sat_counter, SHALL be used for the following, parameterised by CNT_W with increment and clear inputs:
- zero_cnt.
- one_cnt.
- dwell.

Verification
REQ-032 Drive z=A,B,C,D,E,E,E,A with CNT_W=8 -> zero_evt pulses once, 2 cycles after the first E; dwell goes 1,2,3 then 0; max_zero=3; zero_cnt=1.
REQ-033 Hold z=I for 300 cycles with CNT_W=8 -> one_evt pulses once; dwell saturates at 255; max_one=255; one_cnt=1.
REQ-034 Produce 260 separate E entries -> zero_cnt saturates at 255 and does not wrap; zero_evt still pulses 260 times.
REQ-035 Drive z=E then z=I back-to-back -> zero_evt, then one_evt on the next cycle; dwell goes 1 then 1; both counts equal 1.
REQ-036 Drive z=12 for 2 cycles then z=A -> err_evt is high for 2 cycles; err_sticky stays high; clr drops err_sticky to 0.
REQ-037 Apply clr together with an E entry -> zero_evt=1 and zero_cnt=0. Then apply reset during an I run -> all outputs are 0 the next cycle, with no one_evt.
